fixacc_seg_packer: RTL and testbench
====================================

Name: fixacc_seg_packer

Overview:
- Upstream neighbour of the fixed-point-to-fp64 converter in the fixp_acc path.
- Consumes the fixed-point accumulator register bank streamed out one segment per beat, lowest segment first.
- Locates the most significant non-zero segment.
- Emits one packet per frame in the format {msb_segment, lsb_segment, expo_cs} that the converter expects.

Parameters:
- PRE_REG_WIDTH, 128, width of one accumulator segment.
- PRE_REG_STEP, 64, weight step between adjacent segments in bits. Informational only; no arithmetic in this block.
- DEPTH, 32, number of segments per frame.
- IDX_W, clogb2(DEPTH-1) (5 at default), width of the segment index / expo_cs field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- seg_in_tvalid  in  1  segment beat valid.
- seg_in_tready  out  1  segment beat ready.
- seg_in_tdata  in  PRE_REG_WIDTH  segment value, unsigned.
- seg_in_tlast  in  1  last segment of frame.
- pkt_out_tvalid  out  1  packet valid.
- pkt_out_tready  in  1  packet ready.
- pkt_out_tdata  out  IDX_W+2*PRE_REG_WIDTH  packet, layout {msb, lmb, expo_cs}: [IDX_W-1:0]=expo_cs, next PRE_REG_WIDTH bits=lmb, top PRE_REG_WIDTH bits=msb.
- len_err  out  1  one-cycle pulse: frame force-terminated at DEPTH beats without tlast.

Behaviour:
- Reset (async assert, sync release): pkt_out_tvalid=0, pkt_out_tdata=0, len_err=0, seg_cnt=0, prev_seg=0, hi_idx=0, hi_seg=0, lo_seg=0.
- seg_in_tready = ~pkt_out_tvalid | pkt_out_tready. The combinational path from pkt_out_tready is permitted. Non-last beats also stall under this rule.
- Beat index i = seg_cnt (IDX_W bits), counted from 0 at frame start. Advances on each seg_in handshake.
- On handshake with seg_in_tdata != 0: hi_idx<=i, hi_seg<=seg_in_tdata, lo_seg<=prev_seg.
- prev_seg<=seg_in_tdata on every handshake.
- At i=0 the previous segment is treated as 0, so lo_seg<=0 on a non-zero beat 0.
- Zero segments never update hi_*/lo_*. Zero segments above the highest non-zero one are therefore ignored.
- Frame end is the handshake where seg_in_tlast=1 or i==DEPTH-1.
  - If i==DEPTH-1 and tlast=0, len_err pulses the next cycle. The following beat starts a new frame.
  - A short frame (tlast with i<DEPTH-1) is legal; missing segments are zero.
- On frame end, the next cycle:
  - pkt_out_tvalid=1.
  - Packet built from end-of-frame values, including the final beat.
    - If hi_idx==0: expo_cs=0, lmb=hi_seg (segment 0), msb=0.
    - Else: expo_cs=hi_idx, lmb=segment hi_idx-1, msb=segment hi_idx.
  - All-zero frame: packet all zeros.
  - seg_cnt, prev_seg, hi_*, lo_* clear in the same cycle for the next frame.
- Latency: tlast handshake to pkt_out_tvalid is 1 cycle.
- Frames back-to-back: the next frame's beats accumulate while a packet waits, if the consumer accepts.
- pkt_out_tvalid holds with stable tdata until pkt_out_tready.
- Simultaneous pkt_out handshake and a new frame end: the output register is reloaded, with no bubble.
- pkt_out_tvalid drops only on a handshake with no new frame end.
- No sign handling; segments are unsigned.
- seg_cnt wraps to 0 after DEPTH-1.

Test Plan:
- DEPTH=32. 32 beats: seg3=0x5, seg4=0xA, others 0, tlast on beat 31 -> one packet one cycle later: expo_cs=4, lmb=0x5, msb=0xA; len_err stays 0.
- Only seg0=0x1234, tlast on beat 0 (short frame) -> expo_cs=0, lmb=0x1234, msb=0.
- All-zero 32-beat frame -> packet tdata=0, expo_cs=0.
- 32 beats with no tlast, seg31=1, seg30=0xFF -> len_err pulses once; packet expo_cs=31, msb=1, lmb=0xFF; beat 33 begins a new frame at index 0.
- Hold pkt_out_tready=0 after a packet; drive 3 more beats -> seg_in_tready=0, packet tdata stable. Release tready -> packet accepted, beats resume with no loss or duplication.
- Two 2-beat frames back-to-back with pkt_out_tready=1 ({0x3,0x0} then {0x0,0x7}) -> packets expo_cs=0 lmb=0x3, then expo_cs=1 lmb=0 msb=0x7, on consecutive-frame cycles. Assert rst mid-second-frame -> outputs clear immediately, no packet emitted.

Source files
------------

// File: rtl/fixacc_seg_packer_if.sv
// Stream bundle between the segment source, the packer and the fp64 converter:
// segment beats in, one {msb, lmb, expo_cs} packet out per frame.
interface fixacc_seg_packer_if #(
   parameter int unsigned PRE_REG_WIDTH = 128,
   parameter int unsigned IDX_W         = 5
);
   logic                               seg_in_tvalid;
   logic                               seg_in_tready;
   logic [PRE_REG_WIDTH-1:0]           seg_in_tdata;
   logic                               seg_in_tlast;
   logic                               pkt_out_tvalid;
   logic                               pkt_out_tready;
   logic [IDX_W+2*PRE_REG_WIDTH-1:0]   pkt_out_tdata;
   logic                               len_err;

   modport master (
      output seg_in_tvalid, seg_in_tdata, seg_in_tlast, pkt_out_tready,
      input  seg_in_tready, pkt_out_tvalid, pkt_out_tdata, len_err
   );

   modport slave (
      input  seg_in_tvalid, seg_in_tdata, seg_in_tlast, pkt_out_tready,
      output seg_in_tready, pkt_out_tvalid, pkt_out_tdata, len_err
   );
endinterface

// File: rtl/fixacc_seg_packer.sv
// Finds the most significant non-zero accumulator segment of each frame and emits
// {msb_segment, lsb_segment, expo_cs} for the fixed-point-to-fp64 converter.
module fixacc_seg_packer #(
   parameter int unsigned PRE_REG_WIDTH = 128,
   parameter int unsigned PRE_REG_STEP  = 64,
   parameter int unsigned DEPTH         = 32,
   parameter int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input logic                clk,
   input logic                rst,
   fixacc_seg_packer_if.slave bus
);
   localparam int unsigned PktW = IDX_W + 2 * PRE_REG_WIDTH;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

   // Adjacent segments must overlap for the msb/lmb pair to cover the mantissa.
   if (PRE_REG_STEP > PRE_REG_WIDTH) begin : g_step_chk
      $error("PRE_REG_STEP larger than PRE_REG_WIDTH");
   end

   logic [IDX_W-1:0]         seg_cnt_q, seg_cnt_d;
   logic [IDX_W-1:0]         hi_idx_q, hi_idx_d;
   logic [PRE_REG_WIDTH-1:0] prev_seg_q, prev_seg_d;
   logic [PRE_REG_WIDTH-1:0] hi_seg_q, hi_seg_d;
   logic [PRE_REG_WIDTH-1:0] lo_seg_q, lo_seg_d;
   logic                     pkt_vld_q, pkt_vld_d;
   logic [PktW-1:0]          pkt_data_q, pkt_data_d;
   logic                     len_err_q, len_err_d;

   logic                     seg_hs;
   logic                     at_last;
   logic                     frame_end;
   logic [IDX_W-1:0]         fin_idx;
   logic [PRE_REG_WIDTH-1:0] fin_hi;
   logic [PRE_REG_WIDTH-1:0] fin_lo;

   assign bus.seg_in_tready  = ~pkt_vld_q | bus.pkt_out_tready;
   assign bus.pkt_out_tvalid = pkt_vld_q;
   assign bus.pkt_out_tdata  = pkt_data_q;
   assign bus.len_err        = len_err_q;

   always_comb begin
      seg_hs    = bus.seg_in_tvalid & bus.seg_in_tready;
      at_last   = (seg_cnt_q == LastIdx);
      frame_end = seg_hs & (bus.seg_in_tlast | at_last);

      // Tracker values including the current beat, used both to advance and to pack.
      fin_idx = hi_idx_q;
      fin_hi  = hi_seg_q;
      fin_lo  = lo_seg_q;
      if (seg_hs && (bus.seg_in_tdata != '0)) begin
         fin_idx = seg_cnt_q;
         fin_hi  = bus.seg_in_tdata;
         fin_lo  = (seg_cnt_q == '0) ? '0 : prev_seg_q;
      end

      seg_cnt_d  = seg_cnt_q;
      prev_seg_d = prev_seg_q;
      hi_idx_d   = hi_idx_q;
      hi_seg_d   = hi_seg_q;
      lo_seg_d   = lo_seg_q;
      if (frame_end) begin
         seg_cnt_d  = '0;
         prev_seg_d = '0;
         hi_idx_d   = '0;
         hi_seg_d   = '0;
         lo_seg_d   = '0;
      end else if (seg_hs) begin
         seg_cnt_d  = seg_cnt_q + IDX_W'(1);
         prev_seg_d = bus.seg_in_tdata;
         hi_idx_d   = fin_idx;
         hi_seg_d   = fin_hi;
         lo_seg_d   = fin_lo;
      end

      pkt_vld_d  = pkt_vld_q;
      pkt_data_d = pkt_data_q;
      if (frame_end) begin
         pkt_vld_d = 1'b1;
         // Only segment 0 set: it becomes the low word, msb stays zero.
         if (fin_idx == '0) begin
            pkt_data_d = {{PRE_REG_WIDTH{1'b0}}, fin_hi, {IDX_W{1'b0}}};
         end else begin
            pkt_data_d = {fin_hi, fin_lo, fin_idx};
         end
      end else if (bus.pkt_out_tready) begin
         pkt_vld_d = 1'b0;
      end

      len_err_d = seg_hs & at_last & ~bus.seg_in_tlast;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_cnt_q  <= '0;
         prev_seg_q <= '0;
         hi_idx_q   <= '0;
         hi_seg_q   <= '0;
         lo_seg_q   <= '0;
         pkt_vld_q  <= 1'b0;
         pkt_data_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         seg_cnt_q  <= seg_cnt_d;
         prev_seg_q <= prev_seg_d;
         hi_idx_q   <= hi_idx_d;
         hi_seg_q   <= hi_seg_d;
         lo_seg_q   <= lo_seg_d;
         pkt_vld_q  <= pkt_vld_d;
         pkt_data_q <= pkt_data_d;
         len_err_q  <= len_err_d;
      end
   end
endmodule

// File: tb/tb_fixacc_seg_packer.sv
// Random-stimulus bench for fixacc_seg_packer against a frame-level reference model.
module tb_fixacc_seg_packer;
   localparam int W     = 128;
   localparam int DEPTH = 32;
   localparam int IDX_W = 5;
   localparam int PW    = IDX_W + 2 * W;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   fixacc_seg_packer_if #(.PRE_REG_WIDTH(W), .IDX_W(IDX_W)) bus ();

   fixacc_seg_packer #(
      .PRE_REG_WIDTH(W),
      .PRE_REG_STEP (64),
      .DEPTH        (DEPTH),
      .IDX_W        (IDX_W)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1);
   end

   beat_t        bq[$];
   logic [PW-1:0] exp_q[$];
   logic [W-1:0] cur[$];
   logic         exp_vld = 1'b0;
   logic         exp_len = 1'b0;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Packet for one complete frame: highest non-zero segment and the one below it.
   function automatic logic [PW-1:0] ref_pkt(input logic [W-1:0] s[$]);
      int h = -1;
      for (int k = 0; k < s.size(); k++) if (s[k] != '0) h = k;
      if (h < 0) return '0;
      if (h == 0) return {{W{1'b0}}, s[0], {IDX_W{1'b0}}};
      return {s[h], s[h-1], IDX_W'(h)};
   endfunction

   function automatic logic [W-1:0] rnd_seg();
      case ($urandom_range(0, 2))
         0:       return {$urandom, $urandom, $urandom, $urandom};
         1:       return W'($urandom_range(1, 255));
         default: return W'(1) << $urandom_range(0, W - 1);
      endcase
   endfunction

   task automatic push_beat(input logic [W-1:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      bq.push_back(b);
   endtask

   // One clock: drive at negedge, check after settling, update model, advance.
   task automatic cycle(input logic v, input logic r);
      beat_t b = (bq.size() > 0) ? bq[0] : '0;
      logic  seg_hs;
      logic  fe = 1'b0;
      logic  nl = 1'b0;
      bus.seg_in_tvalid  = v && (bq.size() > 0);
      bus.seg_in_tdata   = b.data;
      bus.seg_in_tlast   = b.last;
      bus.pkt_out_tready = r;
      #1;
      check("len_err", PW'(bus.len_err), PW'(exp_len));
      check("pkt_valid", PW'(bus.pkt_out_tvalid), PW'(exp_vld));
      check("seg_ready", PW'(bus.seg_in_tready), PW'(!exp_vld || r));
      if (bus.pkt_out_tvalid && r) begin
         if (exp_q.size() == 0) check("pkt_queue", PW'(exp_q.size()), PW'(1));
         else begin
            logic [PW-1:0] e = exp_q.pop_front();
            check("pkt_data", bus.pkt_out_tdata, e);
         end
      end
      seg_hs = bus.seg_in_tvalid && bus.seg_in_tready;
      if (seg_hs) begin
         cur.push_back(b.data);
         void'(bq.pop_front());
         if (b.last || cur.size() == DEPTH) begin
            fe = 1'b1;
            nl = !b.last;
            exp_q.push_back(ref_pkt(cur));
            cur.delete();
         end
      end
      exp_len = nl;
      exp_vld = fe || (exp_vld && !r);
      @(negedge clk);
   endtask

   task automatic run_until_empty(input int vpct, input int rpct);
      int guard = 0;
      while ((bq.size() > 0 || exp_vld) && guard < 40000) begin
         cycle($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct);
         guard++;
      end
      check("drain_beats", PW'(bq.size()), PW'(0));
      check("drain_valid", PW'(exp_vld), PW'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_valid", PW'(bus.pkt_out_tvalid), PW'(0));
      check("rst_tdata", bus.pkt_out_tdata, PW'(0));
      check("rst_len_err", PW'(bus.len_err), PW'(0));
      bus.seg_in_tvalid  = 1'b0;
      bus.pkt_out_tready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bq.delete();
      exp_q.delete();
      cur.delete();
      exp_vld = 1'b0;
      exp_len = 1'b0;
   endtask

   task automatic gen_frame();
      int kind = $urandom_range(0, 3);
      int len  = (kind <= 1) ? DEPTH : $urandom_range(1, DEPTH);
      for (int k = 0; k < len; k++) begin
         logic [W-1:0] d = ($urandom_range(0, 4) < 2) ? rnd_seg() : '0;
         push_beat(d, (k == len - 1) && (kind != 1));
      end
   endtask

   initial begin
      logic [PW-1:0] held;
      bus.seg_in_tvalid  = 1'b0;
      bus.seg_in_tdata   = '0;
      bus.seg_in_tlast   = 1'b0;
      bus.pkt_out_tready = 1'b0;
      @(negedge clk);
      do_reset();

      // Segments 3/4 set, tlast on beat 31
      for (int k = 0; k < DEPTH; k++)
         push_beat((k == 3) ? W'(5) : (k == 4) ? W'('hA) : '0, k == DEPTH - 1);
      // Short frame of one beat
      push_beat(W'('h1234), 1'b1);
      // All-zero full frame
      for (int k = 0; k < DEPTH; k++) push_beat('0, k == DEPTH - 1);
      // Full frame with no tlast, then a two-beat frame restarting at index 0
      for (int k = 0; k < DEPTH; k++)
         push_beat((k == 31) ? W'(1) : (k == 30) ? W'('hFF) : '0, 1'b0);
      push_beat('0, 1'b0);
      push_beat(W'(9), 1'b1);
      run_until_empty(100, 100);

      // Back-pressure: packet held while further beats wait
      push_beat(W'(5), 1'b1);
      for (int k = 0; k < 3; k++) push_beat(W'(k + 1), k == 2);
      cycle(1'b1, 1'b1);
      held = bus.pkt_out_tdata;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 1'b0);
         check("stall_tdata", bus.pkt_out_tdata, held);
      end
      run_until_empty(100, 100);

      // Back-to-back two-beat frames, reset in the middle of the second
      push_beat(W'(3), 1'b0);
      push_beat('0, 1'b1);
      push_beat('0, 1'b0);
      push_beat(W'(7), 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      do_reset();
      push_beat('0, 1'b0);
      push_beat(W'(7), 1'b1);
      run_until_empty(100, 100);

      // Random frames with random valid gaps and consumer stalls
      for (int f = 0; f < 150; f++) gen_frame();
      run_until_empty(70, 60);
      for (int f = 0; f < 60; f++) gen_frame();
      run_until_empty(100, 100);
      check("pkt_left", PW'(exp_q.size()), PW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
